// File: rtl/ecpri_pkg.sv
// Shared constants and state encoding for the eCPRI receive path.
package ecpri_pkg;

    localparam logic [15:0] ECPRI_ETYPE   = 16'hAEFE;
    localparam int unsigned ETH_HDR_LEN   = 14;
    localparam int unsigned ECPRI_HDR_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        DROP,
        NOTIFY,
        WAIT_DONE
    } state_e;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/eth_frame_writer.sv
// Writes received Ethernet frames into the packet RAM, keeps only eCPRI frames,
// and hands each good frame to ecpri_rx, stalling input until it is released.
module eth_frame_writer
    import ecpri_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned MIN_LEN     = ETH_HDR_LEN + ECPRI_HDR_LEN,
    parameter int unsigned MAX_LEN     = 1500,
    parameter logic [15:0] ECPRI_ETYPE = ecpri_pkg::ECPRI_ETYPE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic                  in_error,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  recv_pkt,
    output logic [ADDR_WIDTH-1:0] pkt_len,
    input  logic                  rx_done,
    output logic [15:0]           frames_ok,
    output logic [15:0]           frames_dropped
);

    localparam logic [ADDR_WIDTH-1:0] ETYPE_HI_IDX = ADDR_WIDTH'(ETH_HDR_LEN - 2);
    localparam logic [ADDR_WIDTH-1:0] ETYPE_LO_IDX = ADDR_WIDTH'(ETH_HDR_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] MIN_LEN_W    = ADDR_WIDTH'(MIN_LEN);
    localparam logic [ADDR_WIDTH-1:0] MAX_LEN_W    = ADDR_WIDTH'(MAX_LEN);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR_W  = ADDR_WIDTH'(BASE_ADDR);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]   etype_hi_q, etype_hi_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    ram_we_q, ram_we_d;
    logic                    in_ready_q, in_ready_d;
    logic                    recv_pkt_q, recv_pkt_d;
    logic [ADDR_WIDTH-1:0]   pkt_len_q, pkt_len_d;
    logic                    ok_inc_c;
    logic                    drop_inc_c;

    logic                    accept_c;
    logic [ADDR_WIDTH-1:0]   idx_c;
    logic [ADDR_WIDTH-1:0]   len_c;
    logic                    oversize_c;
    logic                    etype_bad_c;
    logic                    frame_good_c;

    // Byte index is implicitly 0 in IDLE so count_q never needs clearing.
    assign accept_c     = in_valid && in_ready_q;
    assign idx_c        = (state_q == IDLE) ? '0 : count_q;
    assign len_c        = idx_c + ADDR_WIDTH'(1);
    assign oversize_c   = (idx_c >= MAX_LEN_W);
    assign etype_bad_c  = (idx_c == ETYPE_LO_IDX) &&
                          (16'({etype_hi_q, in_data}) != ECPRI_ETYPE);
    assign frame_good_c = !in_error && (len_c >= MIN_LEN_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, WRITE: begin
                if (accept_c) begin
                    if (oversize_c || etype_bad_c) begin
                        state_d = in_last ? IDLE : DROP;
                    end else if (in_last) begin
                        state_d = frame_good_c ? NOTIFY : IDLE;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            DROP: begin
                if (accept_c && in_last) begin
                    state_d = IDLE;
                end
            end
            NOTIFY:    state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (rx_done) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        etype_hi_d  = etype_hi_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        recv_pkt_d  = 1'b0;
        pkt_len_d   = pkt_len_q;
        ok_inc_c    = 1'b0;
        drop_inc_c  = 1'b0;
        in_ready_d  = (state_d == IDLE) || (state_d == WRITE) || (state_d == DROP);
        unique case (state_q)
            IDLE, WRITE: begin
                if (accept_c) begin
                    count_d = len_c;
                    if (idx_c == ETYPE_HI_IDX) begin
                        etype_hi_d = in_data;
                    end
                    if (!oversize_c) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = BASE_ADDR_W + idx_c;
                        ram_wdata_d = in_data;
                    end
                    if (state_d == NOTIFY) begin
                        recv_pkt_d = 1'b1;
                        pkt_len_d  = len_c;
                    end
                    // Any frame ending here without NOTIFY was rejected.
                    if (in_last && (state_d == IDLE)) begin
                        drop_inc_c = 1'b1;
                    end
                end
            end
            DROP: begin
                if (accept_c && in_last) begin
                    drop_inc_c = 1'b1;
                end
            end
            NOTIFY:  ok_inc_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            etype_hi_q  <= '0;
            ram_addr_q  <= BASE_ADDR_W;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            recv_pkt_q  <= 1'b0;
            pkt_len_q   <= '0;
        end else begin
            count_q     <= count_d;
            etype_hi_q  <= etype_hi_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            in_ready_q  <= in_ready_d;
            recv_pkt_q  <= recv_pkt_d;
            pkt_len_q   <= pkt_len_d;
        end
    end

    sat_counter16 u_ok_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .inc_i   (ok_inc_c),
        .count_o (frames_ok)
    );

    sat_counter16 u_drop_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .inc_i   (drop_inc_c),
        .count_o (frames_dropped)
    );

    assign in_ready  = in_ready_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_cs    = ram_we_q;
    assign ram_oe    = 1'b0;
    assign recv_pkt  = recv_pkt_q;
    assign pkt_len   = pkt_len_q;

endmodule

// File: tb/tb_eth_frame_writer.sv
// Scoreboard bench for eth_frame_writer: random frames against a frame-level model.
module tb_eth_frame_writer;

    localparam int MAX_LEN = 1500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_error;
    logic        in_ready;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;
    logic        recv_pkt;
    logic [15:0] pkt_len;
    logic        rx_done;
    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;

    eth_frame_writer dut (
        .clk            (clk),
        .reset          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_error       (in_error),
        .in_ready       (in_ready),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_cs         (ram_cs),
        .ram_we         (ram_we),
        .ram_oe         (ram_oe),
        .recv_pkt       (recv_pkt),
        .pkt_len        (pkt_len),
        .rx_done        (rx_done),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [23:0] exp_wr_q[$];
    logic [15:0] exp_len_q[$];
    int          exp_ok   = 0;
    int          exp_drop = 0;
    bit          resp_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_cs"}, 32'(ram_cs), 32'd0);
        chk({tag, "_ram_oe"}, 32'(ram_oe), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_recv_pkt"}, 32'(recv_pkt), 32'd0);
        chk({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
        chk({tag, "_frames_ok"}, 32'(frames_ok), 32'd0);
        chk({tag, "_frames_dropped"}, 32'(frames_dropped), 32'd0);
    endtask

    // Called and returns at a negedge; the byte is accepted on the posedge in between.
    task automatic drive_byte(input logic [7:0] d, input logic last, input logic err);
        int budget;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_data  = d;
        in_last  = last;
        in_error = err;
        in_valid = 1'b1;
        budget   = 0;
        while (!in_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 3000) begin
                chk("ready_timeout", 32'(in_ready), 32'd1);
                finish_test();
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (resp_busy || !in_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 500) begin
                chk("idle_timeout", 32'(in_ready), 32'd1);
                finish_test();
            end
        end
    endtask

    // etype_mode: 0 = AE FE, 1 = 08 00, 2 = random bytes
    task automatic run_frame(input int len, input int etype_mode, input bit err);
        logic [7:0]  b[$];
        logic [15:0] et;
        int          n_wr;
        bit          good;
        for (int i = 0; i < len; i++) b.push_back(8'($urandom));
        if (len > 13) begin
            if (etype_mode == 0) begin
                b[12] = 8'hAE;
                b[13] = 8'hFE;
            end else if (etype_mode == 1) begin
                b[12] = 8'h08;
                b[13] = 8'h00;
            end
        end
        et   = (len >= 14) ? {b[12], b[13]} : 16'hAEFE;
        n_wr = len;
        if (len >= 14 && et != 16'hAEFE) n_wr = 14;
        if (n_wr > MAX_LEN) n_wr = MAX_LEN;
        good = (len >= 18) && (len <= MAX_LEN) && (et == 16'hAEFE) && !err;
        for (int i = 0; i < n_wr; i++) exp_wr_q.push_back({16'(i), b[i]});
        if (good) begin
            exp_len_q.push_back(16'(len));
            exp_ok++;
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < len; i++) begin
            drive_byte(b[i], i == len - 1, (i == len - 1) ? err : 1'($urandom));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_error = 1'b0;
        repeat (3) @(negedge clk);
        chk("frames_ok", 32'(frames_ok), 32'(exp_ok));
        chk("frames_dropped", 32'(frames_dropped), 32'(exp_drop));
        chk("writes_pending", 32'(exp_wr_q.size()), 32'd0);
        chk("recv_pending", 32'(exp_len_q.size()), 32'd0);
    endtask

    // Monitor: every RAM write and every recv_pkt must match the head of its queue.
    always @(negedge clk) begin
        logic [23:0] e;
        logic [15:0] l;
        if (rst_n) begin
            if (ram_we) begin
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_write", {8'h0, ram_addr, ram_wdata}, 32'hFFFFFFFF);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk("ram_write", {8'h0, ram_addr, ram_wdata}, {8'h0, e});
                    chk("ram_ctrl", {30'h0, ram_cs, ram_oe}, 32'h2);
                end
            end
            if (recv_pkt) begin
                if (exp_len_q.size() == 0) begin
                    chk("unexpected_recv", 32'(pkt_len), 32'hFFFFFFFF);
                end else begin
                    l = exp_len_q.pop_front();
                    chk("pkt_len", 32'(pkt_len), 32'(l));
                end
            end
        end
    end

    // Plays ecpri_rx: releases the buffer a random time after each recv_pkt.
    initial begin : responder
        int wait_n;
        rx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && recv_pkt) begin
                resp_busy = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    rx_done = 1'b1;
                    @(negedge clk);
                    rx_done = 1'b0;
                end else begin
                    @(negedge clk);
                end
                wait_n = $urandom_range(1, 12);
                repeat (wait_n) begin
                    chk("ready_while_waiting", 32'(in_ready), 32'd0);
                    @(negedge clk);
                end
                rx_done = 1'b1;
                @(negedge clk);
                rx_done = 1'b0;
                chk("ready_after_done", 32'(in_ready), 32'd1);
                resp_busy = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [7:0] b;
        int         len;
        int         sel;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        in_error = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        run_frame(64, 0, 1'b0);
        run_frame(64, 1, 1'b0);
        run_frame(64, 0, 1'b1);
        run_frame(1510, 0, 1'b0);
        run_frame(10, 0, 1'b0);

        for (int f = 0; f < 24; f++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0:       len = 1;
                1:       len = 13;
                2:       len = 14;
                3:       len = 17;
                4:       len = 18;
                default: len = $urandom_range(19, 200);
            endcase
            sel = $urandom_range(0, 9);
            run_frame(len, (sel == 0) ? 1 : ((sel == 1) ? 2 : 0), $urandom_range(0, 9) == 0);
        end

        wait_idle();
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom);
            if (i == 12) b = 8'hAE;
            if (i == 13) b = 8'hFE;
            exp_wr_q.push_back({16'(i), b});
            drive_byte(b, 1'b0, 1'b0);
        end
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset("mid_reset");
        chk("mid_reset_writes_pending", 32'(exp_wr_q.size()), 32'd0);
        exp_ok   = 0;
        exp_drop = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(64, 0, 1'b0);
        chk("post_reset_ok", 32'(frames_ok), 32'd1);

        wait_idle();
        chk("final_writes_pending", 32'(exp_wr_q.size()), 32'd0);
        chk("final_recv_pending", 32'(exp_len_q.size()), 32'd0);
        finish_test();
    end

endmodule

// File: doc/eth_frame_writer.md
Name: eth_frame_writer

Overview:
Upstream neighbour of ecpri_rx. Accepts the received Ethernet byte stream from the MAC, writes each frame into port 0 of the received-packet dual-port RAM (ram_dp_sr_sw), and filters for eCPRI EtherType 0xAEFE. On a good frame it pulses recv_pkt with the frame length, then holds off further input until ecpri_rx reports it has consumed the buffer.

Parameters:
DATA_WIDTH, 8, byte lane width; fixed at 8.
ADDR_WIDTH, 16, RAM address and length width.
BASE_ADDR, 0, RAM address of frame byte 0.
MIN_LEN, 18, minimum accepted frame length in bytes: 14-byte Ethernet header plus 4-byte eCPRI common header.
MAX_LEN, 1500, maximum accepted frame length in bytes; must be at most the RAM depth.
ECPRI_ETYPE, 16'hAEFE, required EtherType at bytes 12-13.

Ports:
clk  in  1  single clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset.
in_data  in  8  stream byte.
in_valid  in  1  byte present.
in_last  in  1  final byte of frame; qualified by in_valid.
in_error  in  1  MAC error flag (bad FCS); sampled only on the last beat.
in_ready  out  1  writer can accept a byte.
ram_addr  out  ADDR_WIDTH  RAM port 0 address.
ram_wdata  out  8  RAM port 0 write data; the top level drives the bidirectional data_0 from this while ram_oe=0.
ram_cs  out  1  chip select.
ram_we  out  1  write enable.
ram_oe  out  1  output enable; held 0 because this block only writes.
recv_pkt  out  1  one-cycle pulse: a good frame is in RAM.
pkt_len  out  ADDR_WIDTH  frame length in bytes; valid from recv_pkt until the next frame starts.
rx_done  in  1  one-cycle pulse from ecpri_rx: buffer is free.
frames_ok  out  16  count of good frames; saturates at 16'hFFFF.
frames_dropped  out  16  count of dropped frames; saturates at 16'hFFFF.

Behaviour:
- Reset values (asynchronous, when reset=0): state IDLE, in_ready=0, ram_cs=0, ram_we=0, ram_oe=0, ram_addr=BASE_ADDR, ram_wdata=0, recv_pkt=0, pkt_len=0, both counters 0, byte count 0.
- A beat is accepted on a posedge where in_valid && in_ready.
- in_ready is 1 in IDLE, WRITE and DROP; it is 0 in NOTIFY and WAIT_DONE.
- States:
  - IDLE: the first accepted beat is byte 0 and moves to WRITE.
  - WRITE: each accepted beat is written into RAM.
  - DROP: beats are accepted and discarded.
  - NOTIFY: one cycle long.
  - WAIT_DONE: waits for rx_done.
- Write timing: ram_addr/ram_wdata/ram_we/ram_cs are registered. A byte accepted at edge k appears on the RAM port during the cycle after k, with ram_addr = BASE_ADDR + byte index. Otherwise ram_we=0 and ram_cs=0.
- EtherType check: bytes 12 and 13 are compared big-endian with ECPRI_ETYPE. On mismatch at byte 13, go to DROP; if that byte also carries in_last, go straight to IDLE.
- Oversize: accepting byte index MAX_LEN (the (MAX_LEN+1)th byte) without in_last goes to DROP. That byte is not written.
- On the last beat:
  - if the length is below MIN_LEN, or in_error=1, the frame is dropped and the state goes to IDLE;
  - otherwise pkt_len <= count and the state goes to NOTIFY.
- NOTIFY: recv_pkt=1 for exactly one cycle, then frames_ok increments and the state goes to WAIT_DONE.
- DROP: exits to IDLE on the accepted in_last beat. frames_dropped increments once per dropped frame, whatever the drop cause.
- Bytes of a dropped frame already written to RAM stay there; this is harmless because recv_pkt is never raised for that frame.
- WAIT_DONE: rx_done=1 moves to IDLE on the next edge. rx_done in any other state is ignored, including an rx_done coinciding with recv_pkt.
- Single-byte frame (in_last on byte 0): dropped as a runt.
- A reset assertion mid-frame aborts the frame immediately. No counter is updated, and recv_pkt does not assert for the aborted frame.

Decomposition:
- Shared package ecpri_pkg holds ECPRI_ETYPE, the Ethernet header length (14), the eCPRI common header length (4), and the state enum typedef (IDLE, WRITE, DROP, NOTIFY, WAIT_DONE).
- One natural sub-module: sat_counter16, a 16-bit saturating counter with increment enable, instantiated twice.

Test Plan:
- 64-byte frame with bytes 12-13 = AE FE, no error -> 64 RAM writes at addresses 0..63 matching the input; recv_pkt pulses once; pkt_len=64; frames_ok=1; in_ready=0 until rx_done, then 1 the cycle after.
- 64-byte frame with EtherType 08 00 -> writes stop after byte 13; no recv_pkt; frames_dropped=1; next good frame accepted normally.
- Good EtherType but in_error=1 on the last beat -> no recv_pkt; frames_dropped=1; frames_ok unchanged.
- 1501-byte stream -> last write at address 1499; DROP until in_last; frames_dropped=1; a 10-byte frame afterwards is dropped as a runt (frames_dropped=2).
- Second frame offered while in WAIT_DONE -> in_ready=0 and no RAM writes; after an rx_done pulse it is written from address 0 and pkt_len updates.
- reset driven low at byte 30 of a good frame -> all outputs return to reset values asynchronously; after release a full good frame yields recv_pkt and frames_ok=1.
